// File: rtl/compat_cache_sa.sv
// compat_cache_sa: set-associative write-through word cache between core and memory req/gnt/rvalid ports.
// Optional hit/miss statistics counters are built when COMPAT_CACHE_STATS_EN is defined.
module compat_cache_sa #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int STAT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic        core_we_i,
  input  logic        core_req_i,
  input  logic [3:0]  core_be_i,
  output logic [31:0] core_rdata_o,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic        core_error_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_error_i,
  input  logic        flush_i,
  output logic        busy_o
`ifdef COMPAT_CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_cnt_o,
  output logic [STAT_W-1:0] miss_cnt_o
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP, FLUSH} state_t;
  state_t state, state_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, rdata_q, hit_data, merged;
  logic [3:0] be_q;
  logic we_q, err_q, flush_q, hit;
  logic [PTR_W-1:0] hit_way, victim, ptr_nxt;
  logic [WAYS-1:0] valid [SETS];
  logic [PTR_W-1:0] ptr [SETS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [31:0] data_mem [SETS][WAYS];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^core_addr_i[1:0];
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[29:IDX_W];
  assign core_gnt_o = state == IDLE && !flush_q && core_req_i;
  assign core_rvalid_o = state == RESP;
  assign core_rdata_o = rdata_q;
  assign core_error_o = core_rvalid_o && err_q;
  assign mem_req_o = state inside {RD_REQ, WR_REQ};
  assign mem_we_o = state == WR_REQ;
  assign mem_be_o = state == WR_REQ ? be_q : state == RD_REQ ? 4'hF : 4'h0;
  assign mem_addr_o = {addr_q, 2'b00};
  assign mem_wdata_o = wdata_q;
  assign busy_o = state != IDLE;
  assign ptr_nxt = (ptr[idx] == PTR_W'(WAYS - 1)) ? '0 : ptr[idx] + 1'b1;
  // Downward scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = ptr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag_mem[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = PTR_W'(w);
      end
      if (!valid[idx][w]) victim = PTR_W'(w);
    end
    hit_data = data_mem[idx][hit_way];
    merged = hit_data;
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : hit_data[8*b +: 8];
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = flush_q ? FLUSH : core_req_i ? LOOKUP : IDLE;
      LOOKUP:  state_d = we_q ? WR_REQ : hit ? RESP : RD_REQ;
      RD_REQ:  state_d = mem_gnt_i ? RD_WAIT : RD_REQ;
      RD_WAIT: state_d = mem_rvalid_i ? RESP : RD_WAIT;
      WR_REQ:  state_d = mem_gnt_i ? WR_WAIT : WR_REQ;
      WR_WAIT: state_d = mem_rvalid_i ? RESP : WR_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      flush_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s] <= '0;
      end
    end else begin
      flush_q <= flush_i || (flush_q && state != FLUSH);
      if (core_gnt_o) begin
        addr_q <= core_addr_i[31:2];
        wdata_q <= core_wdata_i;
        we_q <= core_we_i;
        be_q <= core_be_i;
      end
      if (state == LOOKUP && !we_q && hit) begin
        rdata_q <= hit_data;
        err_q <= 1'b0;
      end
      if (state == RD_WAIT && mem_rvalid_i) begin
        rdata_q <= mem_rdata_i;
        err_q <= mem_error_i;
        if (!mem_error_i) begin
          valid[idx][victim] <= 1'b1;
          ptr[idx] <= ptr_nxt;
        end
      end
      if (state == WR_WAIT && mem_rvalid_i) begin
        rdata_q <= '0;
        err_q <= mem_error_i;
      end
      if (state == FLUSH)
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          ptr[s] <= '0;
        end
    end
  end
  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT && mem_rvalid_i && !mem_error_i) begin
      tag_mem[idx][victim] <= tag;
      data_mem[idx][victim] <= mem_rdata_i;
    end
    if (state == LOOKUP && we_q && hit) data_mem[idx][hit_way] <= merged;
  end
`ifdef COMPAT_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else if (state == LOOKUP) begin
      if (hit && !(&hit_cnt_o)) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (!hit && !(&miss_cnt_o)) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`else
  localparam int unused_stat_w = STAT_W;
`endif
endmodule

// File: tb/tb_compat_cache_sa.sv
// tb_compat_cache_sa: vector table plus scoreboard bench for compat_cache_sa with a stalling memory model.
module tb_compat_cache_sa;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  logic core_we_i = 1'b0, core_req_i = 1'b0;
  logic [3:0] core_be_i = '0;
  logic [31:0] core_rdata_o, mem_addr_o, mem_wdata_o;
  logic core_gnt_o, core_rvalid_o, core_error_o, mem_we_o, mem_req_o, busy_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_rdata_i = '0;
  logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_error_i = 1'b0;
  logic flush_i = 1'b0;
`ifdef COMPAT_CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  compat_cache_sa dut (
    .clk(clk), .reset_n(reset_n),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i), .core_we_i(core_we_i),
    .core_req_i(core_req_i), .core_be_i(core_be_i), .core_rdata_o(core_rdata_o),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_error_o(core_error_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_req_o(mem_req_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_error_i(mem_error_i),
    .flush_i(flush_i), .busy_o(busy_o)
`ifdef COMPAT_CACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic merr;
    logic [31:0] rdata; logic err; logic hit; int mem;
  } vec_t;
  typedef struct { logic [31:0] d; logic e; } exp_t;

  int tests = 0, fails = 0, n_rd = 0, n_wr = 0, n_resp = 0, exp_hits = 0, exp_miss = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[18];
  logic [31:0] store [logic [31:0]];
  logic [31:0] last_addr = '0, last_wdata = '0, held_addr = '0, pend_data = '0;
  logic [3:0] last_be = '0;
  logic mem_err_next = 1'b0, waited = 1'b0, pend = 1'b0, pend_err = 1'b0, flush_arm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return store.exists(a) ? store[a] : {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input logic merr, input logic [31:0] rd,
                              input logic err, input logic hit, input int mem);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.be = be; v.merr = merr;
    v.rdata = rd; v.err = err; v.hit = hit; v.mem = mem;
    return v;
  endfunction

  // Memory responder: one stall cycle before each grant, response the cycle after grant.
  always @(negedge clk) begin
    logic [31:0] w;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = '0;
    if (pend) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = pend_data; mem_error_i = pend_err; pend = 1'b0;
    end else if (mem_req_o && !waited) begin
      waited = 1'b1; held_addr = mem_addr_o;
    end else if (mem_req_o) begin
      check("mem_addr_stable", mem_addr_o, held_addr);
      waited = 1'b0; mem_gnt_i = 1'b1; pend = 1'b1;
      last_addr = mem_addr_o; last_be = mem_be_o;
      if (mem_we_o) begin
        n_wr++; last_wdata = mem_wdata_o;
        w = mrd(mem_addr_o);
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        store[mem_addr_o] = w;
        pend_data = '0; pend_err = 1'b0;
      end else begin
        n_rd++; pend_data = mrd(mem_addr_o); pend_err = mem_err_next;
      end
    end else waited = 1'b0;
  end

  always @(negedge clk)
    if (reset_n && core_rvalid_o) begin
      n_resp++;
      if (sb.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("resp_rdata", core_rdata_o, mon_e.d);
        check("resp_error", {31'd0, core_error_o}, {31'd0, mon_e.e});
      end
    end

  // Pulses flush_i for one cycle while the armed read sits in RD_WAIT.
  always @(posedge clk) begin
    #1;
    if (flush_i) flush_i = 1'b0;
    else if (flush_arm && mem_gnt_i && !mem_we_o) begin
      flush_i = 1'b1; flush_arm = 1'b0;
    end
  end

  task automatic do_access(input vec_t v, input int id);
    int rd0, wr0, lat, req_lat, g;
    exp_t e;
    rd0 = n_rd; wr0 = n_wr; req_lat = 0;
    mem_err_next = v.merr;
    e.d = v.rdata; e.e = v.err;
    sb.push_back(e);
    if (v.hit) exp_hits++; else exp_miss++;
    core_req_i = 1'b1; core_we_i = v.we; core_addr_i = v.addr; core_wdata_i = v.wdata; core_be_i = v.be;
    g = 0;
    #1;
    while (!core_gnt_o && g < 50) begin @(negedge clk); #1; g++; end
    if (!core_gnt_o) begin
      check($sformatf("gnt_timeout_%0d", id), 32'd0, 32'd1);
      core_req_i = 1'b0; sb.delete();
      return;
    end
    @(posedge clk);
    #1 core_req_i = 1'b0; core_we_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (mem_req_o && req_lat == 0) req_lat = lat;
    end while (!core_rvalid_o && lat < 100);
    check($sformatf("rvalid_seen_%0d", id), {31'd0, core_rvalid_o}, 32'd1);
    if (v.mem == 0) check($sformatf("hit_latency_%0d", id), lat, 32'd2);
    else check($sformatf("mem_req_latency_%0d", id), req_lat, 32'd2);
    check($sformatf("mem_reads_%0d", id), n_rd - rd0, (v.mem == 1) ? 32'd1 : 32'd0);
    check($sformatf("mem_writes_%0d", id), n_wr - wr0, (v.mem == 2) ? 32'd1 : 32'd0);
    if (v.mem == 1) check($sformatf("mem_rd_addr_%0d", id), last_addr, {v.addr[31:2], 2'b00});
    if (v.mem == 2) begin
      check($sformatf("mem_wr_be_%0d", id), {28'd0, last_be}, {28'd0, v.be});
      check($sformatf("mem_wr_data_%0d", id), last_wdata, v.wdata);
    end
  endtask

  initial begin
    int g, r0;
    store[32'h0000_1004] = 32'hDEAD_BEEF;
    store[32'h0000_0200] = 32'h1122_3344;
    vecs[0]  = mk(0, 32'h1004, 0, 4'hF, 0, 32'hDEAD_BEEF, 0, 0, 1);
    vecs[1]  = mk(0, 32'h1004, 0, 4'hF, 0, 32'hDEAD_BEEF, 0, 1, 0);
    vecs[2]  = mk(0, 32'h0100, 0, 4'hF, 0, mrd(32'h0100), 0, 0, 1);
    vecs[3]  = mk(0, 32'h1100, 0, 4'hF, 0, mrd(32'h1100), 0, 0, 1);
    vecs[4]  = mk(0, 32'h2100, 0, 4'hF, 0, mrd(32'h2100), 0, 0, 1);
    vecs[5]  = mk(0, 32'h1100, 0, 4'hF, 0, mrd(32'h1100), 0, 1, 0);
    vecs[6]  = mk(0, 32'h2100, 0, 4'hF, 0, mrd(32'h2100), 0, 1, 0);
    vecs[7]  = mk(0, 32'h0100, 0, 4'hF, 0, mrd(32'h0100), 0, 0, 1);
    vecs[8]  = mk(0, 32'h0200, 0, 4'hF, 0, 32'h1122_3344, 0, 0, 1);
    vecs[9]  = mk(1, 32'h0200, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 0, 1, 2);
    vecs[10] = mk(0, 32'h0200, 0, 4'hF, 0, 32'h11BB_33DD, 0, 1, 0);
    vecs[11] = mk(1, 32'h0300, 32'h5566_7788, 4'hF, 0, 32'h0, 0, 0, 2);
    vecs[12] = mk(0, 32'h0300, 0, 4'hF, 0, 32'h5566_7788, 0, 0, 1);
    vecs[13] = mk(0, 32'h0040, 0, 4'hF, 1, mrd(32'h0040), 1, 0, 1);
    vecs[14] = mk(0, 32'h0040, 0, 4'hF, 0, mrd(32'h0040), 0, 0, 1);
    vecs[15] = mk(0, 32'h1004, 0, 4'hF, 0, 32'hDEAD_BEEF, 0, 1, 0);
    vecs[16] = mk(1, 32'h1004, 32'h0102_0304, 4'b1010, 0, 32'h0, 0, 1, 2);
    vecs[17] = mk(0, 32'h1004, 0, 4'hF, 0, 32'h01AD_03EF, 0, 1, 0);

    repeat (2) @(negedge clk);
    check("rst_ctrl", {24'd0, core_gnt_o, core_rvalid_o, core_error_o, mem_req_o, mem_we_o, busy_o, 2'b00}, 32'd0);
    check("rst_be", {28'd0, mem_be_o}, 32'd0);
    check("rst_rdata", core_rdata_o, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
`ifdef COMPAT_CACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt_o, 32'd0);
    check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) do_access(vecs[i], i);

    // Flush raised during RD_WAIT: read completes, next request waits for FLUSH, then misses.
    flush_arm = 1'b1;
    do_access(mk(0, 32'h0700, 0, 4'hF, 0, mrd(32'h0700), 0, 0, 1), 100);
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = 32'h0700; core_be_i = 4'hF;
    #1 check("gnt_blocked_by_flush", {31'd0, core_gnt_o}, 32'd0);
    core_req_i = 1'b0;
    do_access(mk(0, 32'h0700, 0, 4'hF, 0, mrd(32'h0700), 0, 0, 1), 101);
    do_access(mk(0, 32'h1004, 0, 4'hF, 0, 32'h01AD_03EF, 0, 0, 1), 102);

`ifdef COMPAT_CACHE_STATS_EN
    check("hit_cnt", hit_cnt_o, exp_hits);
    check("miss_cnt", miss_cnt_o, exp_miss);
`endif

    // Reset while a read request is outstanding on the memory side.
    @(negedge clk);
    mem_err_next = 1'b0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0600; core_be_i = 4'hF;
    g = 0;
    #1;
    while (!core_gnt_o && g < 50) begin @(negedge clk); #1; g++; end
    @(posedge clk);
    #1 core_req_i = 1'b0;
    g = 0;
    while (!mem_req_o && g < 20) begin @(posedge clk); #2; g++; end
    check("mid_reset_req_seen", {31'd0, mem_req_o}, 32'd1);
    r0 = n_resp;
    reset_n = 1'b0;
    #1;
    check("mid_reset_req_drop", {31'd0, mem_req_o}, 32'd0);
    check("mid_reset_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_resp_after_reset", n_resp, r0);
`ifdef COMPAT_CACHE_STATS_EN
    check("stats_cleared", hit_cnt_o | miss_cnt_o, 32'd0);
`endif
    do_access(mk(0, 32'h1004, 0, 4'hF, 0, 32'h01AD_03EF, 0, 0, 1), 103);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
